// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter.
//   owner_t : bus ownership state (FREE, or locked to requester 0 or 1)
//   N_REQ   : number of requesters served by the arbiter
//   own_of  : maps a requester index to its locked ownership state
package sram_arb_pkg;

  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  function automatic owner_t own_of(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/sram.sv
// Single-port synchronous SRAM macro model.
// Ports:
//   clk      : clock, write and read both occur on the rising edge
//   addr     : word address (depth = 2**ADDR)
//   data_in  : write data
//   write_en : 1 = write data_in to mem[addr] at the rising edge
//   data_out : registered read data, mem[addr] as it was before the edge
module sram #(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic [ADDR-1:0]  addr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             write_en,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [2**ADDR];

  // NOTE: the storage array has no reset; clearing a memory costs a write
  // port per word and the contents are defined by the first write anyway.
  always_ff @(posedge clk) begin
    if (write_en) mem[addr] <= data_in;
    data_out <= mem[addr];
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester front end for the single-port sram macro.
// Round-robin arbitration on ties, optional lock to hold ownership across a
// burst, and a one-cycle read response returned on a shared data bus.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid[1:0]       : per-requester request valid
//   req_ready[1:0]       : per-requester grant (combinational, one-hot or zero)
//   req_we[1:0]          : 1 = write, 0 = read
//   req_lock[1:0]        : keep ownership after this transfer
//   req_addr0/1          : per-requester address
//   req_wdata0/1         : per-requester write data
//   rsp_valid[1:0]       : read response valid, one-hot per requester
//   rsp_rdata            : read data, zero when no response is pending
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] req_ready,
  input  logic [N_REQ-1:0] req_we,
  input  logic [N_REQ-1:0] req_lock,
  input  logic [ADDR-1:0]  req_addr0,
  input  logic [ADDR-1:0]  req_addr1,
  input  logic [WIDTH-1:0] req_wdata0,
  input  logic [WIDTH-1:0] req_wdata1,
  output logic [N_REQ-1:0] rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata
);

  owner_t           state, state_next;
  logic             last_gnt;     // index of the most recently granted requester
  logic [N_REQ-1:0] grant;
  logic             sel;          // index of the granted requester
  logic [ADDR-1:0]  mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  // Grant, SRAM pin mux and next-state decode.
  // NOTE: every output of this block is assigned a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    grant      = '0;
    state_next = state;

    if (!rst) begin
      unique case (state)
        // A tie goes to the requester that did not win last time.
        FREE:    grant = (&req_valid) ? (last_gnt ? 2'b01 : 2'b10) : req_valid;
        // The owner alone may transfer; the other side stalls even if the
        // owner is idle.
        OWN0:    grant = {1'b0, req_valid[0]};
        OWN1:    grant = {req_valid[1], 1'b0};
        default: grant = '0;
      endcase
    end

    sel       = grant[1];
    mem_addr  = sel ? req_addr1  : req_addr0;
    mem_wdata = sel ? req_wdata1 : req_wdata0;
    mem_we    = (|grant) & req_we[sel];

    if (|grant) state_next = req_lock[sel] ? own_of(sel) : FREE;
  end

  assign req_ready = grant;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FREE;
      last_gnt  <= 1'b1;
      rsp_valid <= '0;
    end else begin
      state     <= state_next;
      if (|grant) last_gnt <= sel;
      rsp_valid <= grant & ~req_we;
    end
  end

  sram #(
    .ADDR  (ADDR),
    .WIDTH (WIDTH)
  ) u_sram (
    .clk      (clk),
    .addr     (mem_addr),
    .data_in  (mem_wdata),
    .write_en (mem_we),
    .data_out (mem_rdata)
  );

  // data_out follows every access, including writes; only expose it while a
  // read response is actually pending.
  assign rsp_rdata = (|rsp_valid) ? mem_rdata : '0;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester front end for the single-port `sram` macro: arbitrates per-cycle access between requester 0 and requester 1, with round-robin fairness and an optional lock for back-to-back bursts. It drives the SRAM address, write-data and write-enable pins, and returns read data with a one-cycle response handshake. It sits between the async-FIFO write/read agents (or any two masters) and the shared storage array.

## Interface
- `ADDR`, 4, SRAM address width (depth = 2**ADDR)
- `WIDTH`, 32, data width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid[1:0]`  in  2  per-requester request valid
- `req_ready[1:0]`  out  2  per-requester grant/accept, combinational
- `req_we[1:0]`  in  2  1 = write, 0 = read
- `req_lock[1:0]`  in  2  hold ownership after this transfer
- `req_addr0`, `req_addr1`  in  ADDR  per-requester address
- `req_wdata0`, `req_wdata1`  in  WIDTH  per-requester write data
- `rsp_valid[1:0]`  out  2  read data valid, one-hot per requester
- `rsp_rdata`  out  WIDTH  read data (shared bus, qualified by `rsp_valid`)

## Operation
- Transfer for requester i occurs in the cycle where `req_valid[i] & req_ready[i]`. At most one transfer per cycle; `req_ready` is one-hot or zero.
- Ownership FSM with states `FREE`, `OWN0`, `OWN1`:
  - `FREE`: grant goes to the valid requester. If both are valid, grant goes to the requester opposite the last one granted (`last_gnt`). After reset, `last_gnt`=1, so requester 0 wins the first tie.
  - A transfer with `req_lock[i]`=1 moves the FSM to `OWNi`. A transfer with lock=0 returns it to `FREE`.
  - `OWNi`: only requester i can be granted, and only when `req_valid[i]`=1. The other requester stalls even if i is idle. `OWNi` is left only through a transfer by i with lock=0.
  - `last_gnt` updates on every transfer.
- Granted signals drive the SRAM pins combinationally: `addr`, `data_in`, `write_en = req_we[i]` when granted, and `write_en` = 0 otherwise.
- A read transfer by i in cycle N sets `rsp_valid[i]`=1 in cycle N+1, with `rsp_rdata` = mem[addr] sampled at the edge ending cycle N.
- A write transfer produces no response.
- Responses are not backpressured; the requester must take them.
- Addresses wrap naturally at ADDR bits; there is no range check.

## Timing
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, FSM=`FREE`, `last_gnt`=1, SRAM `write_en`=0. `req_ready` during reset is 0.
- Read latency: exactly 1 cycle, from accept edge to `rsp_valid`. Write commits at the edge ending the accept cycle.
- Read-after-write to the same address in consecutive cycles (either requester) returns the new data.
- Read and write to the same address cannot occur in the same cycle, because only one grant exists per cycle.
- `rst` asserted while a read is outstanding: the response is dropped and `rsp_valid`=0 in the cycle after `rst` samples high. Lock ownership is cleared.
- Deasserting `req_valid` while in `OWNi` does not release ownership.
- Throughput: 1 transfer/cycle sustained. With both requesters continuously valid and unlocked, grants alternate 0,1,0,1…

## Structure
- Package `sram_arb_pkg`:
  - `owner_t` enum (`FREE`, `OWN0`, `OWN1`)
  - `N_REQ`=2
- Sub-module: instantiate existing `sram #(ADDR, WIDTH)` (ports `clk`, `addr`, `data_in`, `write_en`, `data_out`) inside the arbiter. The grant/mux logic stays flat in `sram_arbiter`.
- `rsp_valid` is a 2-bit register. `rsp_rdata` is registered zero when no response is pending; otherwise it passes `data_out`.

## Test plan
- **Reset, then simple write/read:** after reset, req0 writes addr 3 = 32'hDEADBEEF, then reads addr 3. Expect `rsp_valid`=2'b01 one cycle after the read accept, with `rsp_rdata`=32'hDEADBEEF.
- **Fair tie-break:** both requesters continuously valid, unlocked, reading addrs 0 and 1 (preloaded 32'h1, 32'h2). Expect `req_ready` to alternate 01,10,01,…, and `rsp_rdata` to alternate 1,2,1,…
- **Lock burst:** req1 writes addrs 4,5,6 with lock=1,1,0 while req0 is valid. Expect req0 `req_ready`=0 for all three cycles, then granted on the 4th. Reading back addrs 4–6 returns the written values.
- **Lock with idle owner:** req1 locks, then drops `req_valid` for 3 cycles while req0 is valid. Expect no grants until req1 completes a transfer with lock=0.
- **Read-after-write across requesters:** req0 writes addr 15 = 32'hA5A5A5A5 in cycle N, and req1 reads addr 15 in cycle N+1. Expect `rsp_valid`=2'b10 with 32'hA5A5A5A5. A separate step verifies address wrap to 0 when incrementing from 15.
- **Reset mid-operation:** assert `rst` in the cycle after a read accept while req0 holds a lock. Expect `rsp_valid`=0 on the next cycle and FSM `FREE`. The first tie after reset grants req0.
